// File: rtl/udp_perf_pkt_gen_pkg.sv
// Shared definitions for the UDP performance-test packet generator.
// FSM encoding, beat geometry and data-word field widths.
package udp_perf_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        FINISH
    } state_t;

    localparam int BEAT_BYTES = 64;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int SEQ_W      = 22;
    localparam int BEAT_IDX_W = 10;
    localparam int WORD_W     = SEQ_W + BEAT_IDX_W;

    // ceil(size/64) in 16 bits; 65535 yields 1024 without overflow
    function automatic logic [15:0] beats_of(input logic [15:0] size);
        return (size >> BEAT_SHIFT) + 16'(size[BEAT_SHIFT-1:0] != '0);
    endfunction

endpackage

// File: rtl/udp_perf_keep_gen.sv
// Last-beat byte-enable mask from the packet length residue.
// A residue of zero means the final beat is full.
module udp_perf_keep_gen (
    input  logic [5:0]  residue,
    output logic [63:0] keep
);

    always_comb begin
        keep = '0;
        for (int i = 0; i < 64; i++) begin
            keep[i] = (residue == 6'd0) || (i < 32'(residue));
        end
    end

endmodule

// File: rtl/udp_perf_pkt_gen.sv
// Synthetic UDP payload generator for throughput tests.
// Emits numbered packets on AXI-Stream with a programmable gap.
module udp_perf_pkt_gen
    import udp_perf_pkt_gen_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 512,
    parameter int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8,
    parameter int AXIS_TUSER_WIDTH = 1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        start,
    input  logic                        stop,
    input  logic [15:0]                 pkt_size,
    input  logic [31:0]                 pkt_interval,
    input  logic [31:0]                 pkt_num,
    output logic                        udp_tx_axis_tvalid,
    input  logic                        udp_tx_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] udp_tx_axis_tdata,
    output logic [AXIS_TKEEP_WIDTH-1:0] udp_tx_axis_tkeep,
    output logic                        udp_tx_axis_tlast,
    output logic [AXIS_TUSER_WIDTH-1:0] udp_tx_axis_tuser,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 sent_pkt_count,
    output logic [31:0]                 sent_beat_count
);

    state_t state, state_nxt;

    logic [15:0]           beats_r;
    logic [5:0]            residue_r;
    logic [31:0]           interval_r;
    logic [31:0]           num_r;
    logic [31:0]           gap_cnt;
    logic [SEQ_W-1:0]      seq;
    logic [BEAT_IDX_W-1:0] beat_idx;
    logic                  stop_pend;

    logic [15:0]       size_eff;
    logic              send;
    logic              accept;
    logic              last_beat;
    logic              stop_now;
    logic              quota;
    logic [63:0]       keep_mask;
    logic [WORD_W-1:0] word;

    assign size_eff  = (pkt_size == 16'd0) ? 16'(BEAT_BYTES) : pkt_size;
    assign send      = (state == SEND);
    assign accept    = send && udp_tx_axis_tready;
    assign last_beat = ({6'd0, beat_idx} == beats_r - 16'd1);
    assign stop_now  = stop_pend || stop;
    assign quota     = (num_r != 32'd0) && (sent_pkt_count + 32'd1 == num_r);
    assign word      = {seq, beat_idx};

    udp_perf_keep_gen u_keep (
        .residue (residue_r),
        .keep    (keep_mask)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = SEND;
            SEND: begin
                if (accept && last_beat) begin
                    if (quota || stop_now)        state_nxt = FINISH;
                    else if (interval_r != 32'd0) state_nxt = GAP;
                    else                          state_nxt = SEND;
                end
            end
            GAP: begin
                if (stop_now)                   state_nxt = FINISH;
                else if (gap_cnt == interval_r) state_nxt = SEND;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state           <= IDLE;
            beats_r         <= '0;
            residue_r       <= '0;
            interval_r      <= '0;
            num_r           <= '0;
            gap_cnt         <= '0;
            seq             <= '0;
            beat_idx        <= '0;
            stop_pend       <= 1'b0;
            sent_pkt_count  <= '0;
            sent_beat_count <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        beats_r         <= beats_of(size_eff);
                        residue_r       <= size_eff[5:0];
                        interval_r      <= pkt_interval;
                        num_r           <= pkt_num;
                        seq             <= '0;
                        beat_idx        <= '0;
                        sent_pkt_count  <= '0;
                        sent_beat_count <= '0;
                        stop_pend       <= stop;
                    end
                end
                SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (accept) begin
                        sent_beat_count <= sent_beat_count + 32'd1;
                        if (last_beat) begin
                            beat_idx       <= '0;
                            seq            <= seq + 1'b1;
                            sent_pkt_count <= sent_pkt_count + 32'd1;
                            gap_cnt        <= 32'd1;
                        end else begin
                            beat_idx <= beat_idx + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (stop) stop_pend <= 1'b1;
                    gap_cnt <= gap_cnt + 32'd1;
                end
                FINISH: stop_pend <= 1'b0;
                default: stop_pend <= 1'b0;
            endcase
        end
    end

    // outputs decode from state so reset clears them without waiting for a clock
    always_comb begin
        udp_tx_axis_tvalid = send;
        udp_tx_axis_tdata  = '0;
        udp_tx_axis_tkeep  = '0;
        udp_tx_axis_tlast  = 1'b0;
        udp_tx_axis_tuser  = '0;
        if (send) begin
            udp_tx_axis_tdata = {(AXIS_TDATA_WIDTH / WORD_W){word}};
            udp_tx_axis_tkeep = last_beat ? keep_mask : '1;
            udp_tx_axis_tlast = last_beat;
        end
    end

    assign busy = (state == SEND) || (state == GAP);
    assign done = (state == FINISH);

endmodule
